// File: rtl/multiword_add_sequencer_pkg.sv
// Shared types and constants for the multi-precision add/subtract sequencer.
// The whole block is built around one 16-bit adder slice.
package multiword_add_sequencer_pkg;

   localparam int SLICE_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // A width of at least one bit keeps the slice index legal at the smallest word count.
   function automatic int idx_width(input int words);
      return (words > 2) ? $clog2(words) : 1;
   endfunction

endpackage

// File: rtl/multiword_add_sequencer_if.sv
// Start/done handshake and operand/result bus between the issuing control logic
// and the multi-precision add/subtract sequencer.
interface multiword_add_sequencer_if #(parameter int WORDS = 4);
   import multiword_add_sequencer_pkg::*;

   logic                     start;
   logic                     op_sub;
   logic [SLICE_W*WORDS-1:0] a_in;
   logic [SLICE_W*WORDS-1:0] b_in;
   logic                     ready;
   logic                     done;
   logic [SLICE_W*WORDS-1:0] result;
   logic                     c_out;
   logic                     overflow;

   modport master (
      output start, op_sub, a_in, b_in,
      input  ready, done, result, c_out, overflow
   );

   modport slave (
      input  start, op_sub, a_in, b_in,
      output ready, done, result, c_out, overflow
   );
endinterface

// File: rtl/multiword_add_sequencer_adder.sv
// The team's 16-bit ripple carry adder; purely combinational.
module RippleCarryAdder_16bit (
   output logic        c_out,
   output logic [15:0] sum,
   input  logic        c_in,
   input  logic [15:0] in1,
   input  logic [15:0] in2
);

   logic [16:0] carry;

   assign carry[0] = c_in;

   for (genvar g = 0; g < 16; g++) begin : g_bit
      assign sum[g]       = in1[g] ^ in2[g] ^ carry[g];
      assign carry[g + 1] = (in1[g] & in2[g]) | (carry[g] & (in1[g] ^ in2[g]));
   end

   assign c_out = carry[16];

endmodule

// File: rtl/multiword_add_sequencer.sv
// Multi-precision add/subtract: walks WORDS 16-bit slices through one adder,
// least-significant first, chaining the carry between slices.
module multiword_add_sequencer
   import multiword_add_sequencer_pkg::*;
#(
   parameter int WORDS = 4
) (
   input logic                      clk,
   input logic                      rst_n,
   multiword_add_sequencer_if.slave bus
);

   localparam int IDX_W = idx_width(WORDS);
   localparam int W     = SLICE_W * WORDS;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

   state_t             state;
   state_t             next_state;
   logic [W-1:0]       a_reg;
   logic [W-1:0]       b_reg;
   logic [W-1:0]       result_reg;
   logic               sub_reg;
   logic               carry;
   logic               c_out_reg;
   logic               ovf_reg;
   logic [IDX_W-1:0]   idx;
   logic [SLICE_W-1:0] add_in1;
   logic [SLICE_W-1:0] add_in2;
   logic [SLICE_W-1:0] add_sum;
   logic               add_c_out;
   logic               last_slice;

   // Subtraction is a + ~b + 1: B is inverted per slice and the initial carry is op_sub.
   assign add_in1    = a_reg[int'(idx)*SLICE_W +: SLICE_W];
   assign add_in2    = b_reg[int'(idx)*SLICE_W +: SLICE_W] ^ {SLICE_W{sub_reg}};
   assign last_slice = (idx == LAST_IDX);

   RippleCarryAdder_16bit u_adder (
      .c_out (add_c_out),
      .sum   (add_sum),
      .c_in  (carry),
      .in1   (add_in1),
      .in2   (add_in2)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (bus.start) next_state = RUN;
         RUN:     if (last_slice) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Results are only cleared by reset or a new accepted start, so they hold through DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_reg      <= '0;
         b_reg      <= '0;
         sub_reg    <= 1'b0;
         idx        <= '0;
         carry      <= 1'b0;
         result_reg <= '0;
         c_out_reg  <= 1'b0;
         ovf_reg    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  a_reg      <= bus.a_in;
                  b_reg      <= bus.b_in;
                  sub_reg    <= bus.op_sub;
                  idx        <= '0;
                  carry      <= bus.op_sub;
                  result_reg <= '0;
               end
            end
            RUN: begin
               result_reg[int'(idx)*SLICE_W +: SLICE_W] <= add_sum;
               carry <= add_c_out;
               idx   <= idx + IDX_W'(1);
               if (last_slice) begin
                  c_out_reg <= add_c_out;
                  ovf_reg   <= (add_in1[SLICE_W-1] == add_in2[SLICE_W-1]) &&
                               (add_sum[SLICE_W-1] != add_in1[SLICE_W-1]);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.ready    = (state == IDLE);
   assign bus.done     = (state == DONE);
   assign bus.result   = result_reg;
   assign bus.c_out    = c_out_reg;
   assign bus.overflow = ovf_reg;

endmodule
